// File: rtl/led_status.sv
// rtl/led_status.sv - status LED sequencer: boot-on, detached-off, activity flash, sleep pattern
// Build option: define LED_STATUS_BREATH_EN for PWM breathing in SLEEP; otherwise SLEEP blinks 1 cycle in 8.
module led_status #(
  parameter int BOOT_CYCLES  = 1048576,
  parameter int FLASH_CYCLES = 32768,
  parameter int PWM_BITS     = 8,
  parameter int BREATH_STEP  = 2048
) (
  input  logic       clk_1mhz,
  input  logic       rstn,
  input  logic       sleep_i,
  input  logic       dp_pu_i,
  input  logic       act_tgl_i,
  output logic       led_o,
  output logic [1:0] state_o
);

  localparam int BW = $clog2(BOOT_CYCLES) + 1;
  localparam int FW = $clog2(FLASH_CYCLES) + 1;
  localparam logic [BW-1:0] BOOT_LAST  = BW'(BOOT_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);

  typedef enum logic [1:0] {
    ST_BOOT     = 2'b00,
    ST_DETACHED = 2'b01,
    ST_AWAKE    = 2'b10,
    ST_SLEEP    = 2'b11
  } state_e;

  // Counters below assume room for at least one decrement/wrap.
  if (BOOT_CYCLES < 2 || FLASH_CYCLES < 2 || PWM_BITS < 2 || BREATH_STEP < 2) begin : g_bad_params
    $error("led_status: all parameters must be >= 2");
  end

  // Input synchronisers; the activity toggle gets a third flop for edge detection.
  logic sleep_q1, sleep_q2;
  logic pu_q1, pu_q2;
  logic act_q1, act_q2, act_q3;
  logic act_ev;

  state_e        state_q, state_d, exit_st;
  logic          led_q, led_d;
  logic [BW-1:0] boot_q, boot_d;
  logic [FW-1:0] flash_q, flash_d;
  logic          sleep_led_d;

`ifdef LED_STATUS_BREATH_EN
  localparam int SW = $clog2(BREATH_STEP) + 1;
  localparam logic [SW-1:0]       STEP_LAST = SW'(BREATH_STEP - 1);
  localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;

  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                dir_q, dir_d;   // 0 = rising, 1 = falling
  logic [SW-1:0]       step_q, step_d;
`else
  logic [2:0]          blink_q, blink_d;
`endif

  assign act_ev  = act_q2 ^ act_q3;
  assign led_o   = led_q;
  assign state_o = state_q;

  // Two-flop synchronisation of the asynchronous levels and the activity toggle.
  always_ff @(posedge clk_1mhz or negedge rstn) begin
    if (!rstn) begin
      sleep_q1 <= 1'b0;
      sleep_q2 <= 1'b0;
      pu_q1    <= 1'b0;
      pu_q2    <= 1'b0;
      act_q1   <= 1'b0;
      act_q2   <= 1'b0;
      act_q3   <= 1'b0;
    end else begin
      sleep_q1 <= sleep_i;
      sleep_q2 <= sleep_q1;
      pu_q1    <= dp_pu_i;
      pu_q2    <= pu_q1;
      act_q1   <= act_tgl_i;
      act_q2   <= act_q1;
      act_q3   <= act_q2;
    end
  end

  // Next-state, counter and LED computation; the LED is derived from next-state values
  // so that it changes on the same edge as the state.
  always_comb begin
    state_d     = state_q;
    boot_d      = boot_q;
    flash_d     = '0;
    led_d       = led_q;
    sleep_led_d = 1'b0;

    // Detached beats sleep, which beats awake.
    if (!pu_q2)        exit_st = ST_DETACHED;
    else if (sleep_q2) exit_st = ST_SLEEP;
    else               exit_st = ST_AWAKE;

    if (state_q == ST_BOOT) begin
      if (boot_q == BOOT_LAST) state_d = exit_st;
      else                     boot_d  = boot_q + 1'b1;
    end else begin
      state_d = exit_st;
    end

    // Activity flash lives only in AWAKE; activity during BOOT or on entry to SLEEP is dropped.
    if (state_d == ST_AWAKE) begin
      if (act_ev && state_q != ST_BOOT) flash_d = FLASH_LOAD;
      else if (flash_q != '0)           flash_d = flash_q - 1'b1;
    end

`ifdef LED_STATUS_BREATH_EN
    // Breathing restarts from dark on every entry to SLEEP.
    pwm_d  = '0;
    duty_d = '0;
    dir_d  = 1'b0;
    step_d = '0;
    if (state_q == ST_SLEEP && state_d == ST_SLEEP) begin
      pwm_d  = pwm_q + 1'b1;
      duty_d = duty_q;
      dir_d  = dir_q;
      if (step_q == STEP_LAST) begin
        if (!dir_q) begin
          if (duty_q == DUTY_MAX) begin
            dir_d  = 1'b1;
            duty_d = DUTY_MAX - 1'b1;
          end else begin
            duty_d = duty_q + 1'b1;
          end
        end else begin
          if (duty_q == '0) begin
            dir_d  = 1'b0;
            duty_d = PWM_BITS'(1);
          end else begin
            duty_d = duty_q - 1'b1;
          end
        end
      end else begin
        step_d = step_q + 1'b1;
      end
    end
    sleep_led_d = (pwm_d < duty_d);
`else
    blink_d     = blink_q + 1'b1;
    sleep_led_d = (blink_d == 3'd0);
`endif

    case (state_d)
      ST_BOOT:     led_d = 1'b1;
      ST_DETACHED: led_d = 1'b0;
      ST_AWAKE:    led_d = (flash_d == '0);
      default:     led_d = sleep_led_d;
    endcase
  end

  // State, LED and pattern counter registers.
  always_ff @(posedge clk_1mhz or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_BOOT;
      led_q   <= 1'b0;
      boot_q  <= '0;
      flash_q <= '0;
`ifdef LED_STATUS_BREATH_EN
      pwm_q   <= '0;
      duty_q  <= '0;
      dir_q   <= 1'b0;
      step_q  <= '0;
`else
      blink_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      led_q   <= led_d;
      boot_q  <= boot_d;
      flash_q <= flash_d;
`ifdef LED_STATUS_BREATH_EN
      pwm_q   <= pwm_d;
      duty_q  <= duty_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
`else
      blink_q <= blink_d;
`endif
    end
  end

endmodule

// File: tb/tb_led_status.sv
// tb/tb_led_status.sv - directed bench for led_status (BOOT=16, FLASH=4, PWM_BITS=4, STEP=2)
module tb_led_status;

  logic       clk_1mhz = 1'b0;
  logic       rstn     = 1'b0;
  logic       sleep_i  = 1'b0;
  logic       dp_pu_i  = 1'b1;
  logic       act_tgl_i = 1'b0;
  logic       led_o;
  logic [1:0] state_o;

  int n_vec  = 0;
  int n_bad  = 0;
  int edge_n = 0;

  typedef struct {
    logic       s;
    logic       p;
    logic       t;
    logic [1:0] st;
    logic       led;
  } vec_t;

  vec_t vecs[$];

  led_status #(
    .BOOT_CYCLES (16),
    .FLASH_CYCLES(4),
    .PWM_BITS    (4),
    .BREATH_STEP (2)
  ) dut (
    .clk_1mhz (clk_1mhz),
    .rstn     (rstn),
    .sleep_i  (sleep_i),
    .dp_pu_i  (dp_pu_i),
    .act_tgl_i(act_tgl_i),
    .led_o    (led_o),
    .state_o  (state_o)
  );

  always #5 clk_1mhz = ~clk_1mhz;

  task automatic step();
    @(posedge clk_1mhz);
    #1;
    edge_n++;
  endtask

  task automatic check(input string name, input logic [1:0] est, input logic eled);
    n_vec++;
    if (state_o !== est || led_o !== eled) begin
      n_bad++;
      $display("FAIL %s (edge %0d): state_o=%b led_o=%b, expected state_o=%b led_o=%b",
               name, edge_n, state_o, led_o, est, eled);
    end
  endtask

  // k = edges since SLEEP entry, e = edges since reset release
  function automatic logic exp_sleep_led(input int k, input int e);
`ifdef LED_STATUS_BREATH_EN
    int duty;
    duty = (k <= 30) ? k / 2 : 30 - k / 2;
    return logic'((k % 16) < duty && e >= 0);
`else
    return logic'((e % 8) == 0 && k >= 0);
`endif
  endfunction

  task automatic boot_sequence(input string name, input logic [1:0] exit_st);
    for (int e = 1; e <= 15; e++) begin
      step();
      check({name, "_boot"}, 2'b00, 1'b1);
    end
    step();
    check({name, "_exit"}, exit_st, (exit_st == 2'b11) ? exp_sleep_led(0, edge_n) : 1'b1);
  endtask

  initial begin
    // Table: edge e after release; inputs applied before edge e, outputs checked after it.
    for (int e = 1; e <= 38; e++) begin
      vec_t v;
      v.s   = (e >= 7 && e <= 9) || (e >= 37);
      v.p   = !(e == 4 || e == 5);
      v.t   = (e >= 3 && e <= 7) || (e >= 19 && e <= 26) || (e >= 29 && e <= 36);
      v.st  = (e <= 15) ? 2'b00 : 2'b10;
      v.led = !((e >= 21 && e <= 24) || (e >= 29 && e <= 34));
      vecs.push_back(v);
    end

    repeat (3) step();
    check("reset", 2'b00, 1'b0);

    rstn   = 1'b1;
    edge_n = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      sleep_i   = vecs[i].s;
      dp_pu_i   = vecs[i].p;
      act_tgl_i = vecs[i].t;
      step();
      check($sformatf("vec%0d", i + 1), vecs[i].st, vecs[i].led);
    end

    // Sleep entry; the activity event landing on this edge is dropped.
    step();
    check("sleep_entry", 2'b11, exp_sleep_led(0, edge_n));
    for (int k = 1; k <= 61; k++) begin
      step();
      check($sformatf("sleep_k%0d", k), 2'b11, exp_sleep_led(k, edge_n));
    end

    // Pull-up drop while asleep wins over sleep.
    dp_pu_i = 1'b0;
    repeat (3) step();
    check("detach", 2'b01, 1'b0);
    dp_pu_i = 1'b1;
    step();
    check("reattach_wait1", 2'b01, 1'b0);
    step();
    check("reattach_wait2", 2'b01, 1'b0);
    step();
    check("resleep_entry", 2'b11, exp_sleep_led(0, edge_n));
    for (int k = 1; k <= 31; k++) begin
      step();
      check($sformatf("resleep_k%0d", k), 2'b11, exp_sleep_led(k, edge_n));
    end

    // Wake and activity on the same edge: AWAKE with the flash running.
    sleep_i   = 1'b0;
    act_tgl_i = ~act_tgl_i;
    repeat (3) step();
    check("wake_flash0", 2'b10, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      step();
      check($sformatf("wake_flash%0d", i), 2'b10, 1'b0);
    end
    step();
    check("wake_flash_end", 2'b10, 1'b1);

    // Asynchronous reset in the middle of a flash.
    act_tgl_i = ~act_tgl_i;
    repeat (3) step();
    check("pre_rst_flash", 2'b10, 1'b0);
    #3;
    rstn = 1'b0;
    #1;
    check("async_rst_flash", 2'b00, 1'b0);
    repeat (2) step();
    rstn   = 1'b1;
    edge_n = 0;
    boot_sequence("reboot1", 2'b10);

    // Asynchronous reset in the middle of breathing; reboot exits straight to SLEEP.
    sleep_i = 1'b1;
    repeat (3) step();
    check("pre_rst_sleep", 2'b11, exp_sleep_led(0, edge_n));
    repeat (20) step();
    #3;
    rstn = 1'b0;
    #1;
    check("async_rst_sleep", 2'b00, 1'b0);
    repeat (2) step();
    rstn   = 1'b1;
    edge_n = 0;
    boot_sequence("reboot2", 2'b11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
